mmio_responder: RTL and testbench

//  Memory-mapped I/O target for the 3-stage core's data path: decodes loads/stores

---
 rtl/mmio_responder_pkg.sv | 16 +
 rtl/mmio_responder_counter.sv | 23 ++
 rtl/mmio_responder.sv | 135 +++++++++++++
 tb/tb_mmio_responder.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_responder_pkg.sv
// MMIO address map shared by the responder and the core's wb_sel/DMEM gating.
// Holds the IO_TOP default and the byte offsets of every mapped register.
package mmio_responder_pkg;

  localparam logic [3:0] IO_TOP_DEF  = 4'h8;

  localparam logic [7:0] MMIO_STATUS = 8'h00;
  localparam logic [7:0] MMIO_RX     = 8'h04;
  localparam logic [7:0] MMIO_TX     = 8'h08;
  localparam logic [7:0] MMIO_CYC    = 8'h10;
  localparam logic [7:0] MMIO_INST   = 8'h14;
  localparam logic [7:0] MMIO_CLR    = 8'h18;
  localparam logic [7:0] MMIO_BR     = 8'h1C;
  localparam logic [7:0] MMIO_BRT    = 8'h20;

endpackage

// File: rtl/mmio_responder_counter.sv
// mmio_counter: wrapping event counter, sync active-low reset, clear beats inc.
// Ports: clk, rst_n, i_inc, i_clr, o_q[CNT_W-1:0].
module mmio_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_q
);

  logic [CNT_W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (!rst_n)     r_q <= '0;
    else if (i_clr) r_q <= '0;
    else if (i_inc) r_q <= r_q + 1'b1;
  end

  assign o_q = r_q;

endmodule

// File: rtl/mmio_responder.sv
// mmio_responder: MMIO target in X, registered read data in MW, UART TX/RX, counters.
// Ports: clk, rst_n, x_* decode, inst_retire, mw_rdata/mw_hit, tx_*, rx_*;
// br_x/br_taken only with BRANCH_STATS_EN defined.
module mmio_responder
  import mmio_responder_pkg::*;
#(
  parameter logic [3:0] IO_TOP = IO_TOP_DEF,
  parameter int         CNT_W  = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] x_addr,
  input  logic [31:0] x_wdata,
  input  logic        x_load,
  input  logic        x_store,
  input  logic        x_valid,
  input  logic        inst_retire,
  output logic [31:0] mw_rdata,
  output logic        mw_hit,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
`ifdef BRANCH_STATS_EN
  ,
  input  logic        br_x,
  input  logic        br_taken
`endif
);

  logic             w_sel;
  logic             w_ld;
  logic             w_st;
  logic [7:0]       w_off;
  logic             w_tx_wr;
  logic             w_clr;
  logic [31:0]      w_rd;
  logic [CNT_W-1:0] w_cyc;
  logic [CNT_W-1:0] w_inst;

  logic [31:0]      r_rdata;
  logic             r_hit;
  logic             r_tx_full;
  logic [7:0]       r_tx_data;

  assign w_sel = x_valid & (x_addr[31:28] == IO_TOP);
  assign w_ld  = w_sel & x_load;
  assign w_st  = w_sel & x_store;
  assign w_off = x_addr[7:0];

  // Full buffer drops the byte, even on the cycle it drains.
  assign w_tx_wr = w_st & (w_off == MMIO_TX) & ~r_tx_full;
  assign w_clr   = w_st & (w_off == MMIO_CLR);

  assign rx_ready = rst_n & w_ld & (w_off == MMIO_RX) & rx_valid;

  mmio_counter #(.CNT_W(CNT_W)) u_cyc (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (1'b1),
    .i_clr (w_clr),
    .o_q   (w_cyc)
  );

  mmio_counter #(.CNT_W(CNT_W)) u_inst (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (inst_retire),
    .i_clr (w_clr),
    .o_q   (w_inst)
  );

`ifdef BRANCH_STATS_EN
  logic [CNT_W-1:0] w_br;
  logic [CNT_W-1:0] w_brt;

  mmio_counter #(.CNT_W(CNT_W)) u_br (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (x_valid & br_x),
    .i_clr (w_clr),
    .o_q   (w_br)
  );

  mmio_counter #(.CNT_W(CNT_W)) u_brt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (x_valid & br_x & br_taken),
    .i_clr (w_clr),
    .o_q   (w_brt)
  );
`endif

  always_comb begin
    w_rd = '0;
    case (w_off)
      MMIO_STATUS: w_rd = {30'b0, rx_valid, ~r_tx_full};
      MMIO_RX:     w_rd = rx_valid ? {24'b0, rx_data} : 32'b0;
      MMIO_CYC:    w_rd = 32'(w_cyc);
      MMIO_INST:   w_rd = 32'(w_inst);
`ifdef BRANCH_STATS_EN
      MMIO_BR:     w_rd = 32'(w_br);
      MMIO_BRT:    w_rd = 32'(w_brt);
`endif
      default:     w_rd = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rdata   <= '0;
      r_hit     <= 1'b0;
      r_tx_full <= 1'b0;
      r_tx_data <= '0;
    end else begin
      r_hit <= w_ld;
      if (w_ld)
        r_rdata <= w_rd;
      if (w_tx_wr) begin
        r_tx_full <= 1'b1;
        r_tx_data <= x_wdata[7:0];
      end else if (r_tx_full & tx_ready) begin
        r_tx_full <= 1'b0;
      end
    end
  end

  assign mw_rdata = r_rdata;
  assign mw_hit   = r_hit;
  assign tx_data  = r_tx_data;
  assign tx_valid = r_tx_full;

endmodule

// File: tb/tb_mmio_responder.sv
// Directed bench for mmio_responder: vector table plus multi-cycle sequences.
// Works with or without BRANCH_STATS_EN defined.
module tb_mmio_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] x_addr;
  logic [31:0] x_wdata;
  logic        x_load;
  logic        x_store;
  logic        x_valid;
  logic        inst_retire;
  logic [31:0] mw_rdata;
  logic        mw_hit;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
`ifdef BRANCH_STATS_EN
  logic        br_x;
  logic        br_taken;
`endif

  int checks = 0;
  int errors = 0;

  mmio_responder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .x_addr      (x_addr),
    .x_wdata     (x_wdata),
    .x_load      (x_load),
    .x_store     (x_store),
    .x_valid     (x_valid),
    .inst_retire (inst_retire),
    .mw_rdata    (mw_rdata),
    .mw_hit      (mw_hit),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready)
`ifdef BRANCH_STATS_EN
    ,
    .br_x        (br_x),
    .br_taken    (br_taken)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ld;
    logic        st;
    logic        v;
    logic        rxv;
    logic [7:0]  rxd;
    logic        e_rxr;
    logic        e_hit;
    logic [31:0] e_rd;
  } vec_t;

  vec_t vt [10];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    x_addr  = '0;
    x_wdata = '0;
    x_load  = 1'b0;
    x_store = 1'b0;
    x_valid = 1'b0;
  endtask

  task automatic ld(input logic [31:0] a);
    x_addr  = a;
    x_wdata = '0;
    x_load  = 1'b1;
    x_store = 1'b0;
    x_valid = 1'b1;
  endtask

  task automatic st(input logic [31:0] a, input logic [31:0] d);
    x_addr  = a;
    x_wdata = d;
    x_load  = 1'b0;
    x_store = 1'b1;
    x_valid = 1'b1;
  endtask

  initial begin
    vt[0] = '{32'h8000_0000, 0, 1, 0, 1, 0, 8'h00, 0, 1, 32'h1};
    vt[1] = '{32'h8000_0000, 0, 1, 0, 1, 1, 8'h00, 0, 1, 32'h3};
    vt[2] = '{32'h8000_0004, 0, 1, 0, 1, 1, 8'h5A, 1, 1, 32'h5A};
    vt[3] = '{32'h0000_0000, 0, 0, 0, 0, 1, 8'h5A, 0, 0, 32'h5A};
    vt[4] = '{32'h8000_0004, 0, 1, 0, 0, 1, 8'h33, 0, 0, 32'h5A};
    vt[5] = '{32'h4000_0004, 0, 1, 0, 1, 1, 8'h33, 0, 0, 32'h5A};
    vt[6] = '{32'h8000_0004, 0, 0, 1, 1, 1, 8'h33, 0, 0, 32'h5A};
    vt[7] = '{32'h8000_000C, 0, 1, 0, 1, 1, 8'h33, 0, 1, 32'h0};
    vt[8] = '{32'h8000_0004, 0, 1, 0, 1, 0, 8'h77, 0, 1, 32'h0};
    vt[9] = '{32'h8000_001C, 0, 1, 0, 1, 0, 8'h00, 0, 1, 32'h0};

    idle();
    rst_n       = 1'b0;
    inst_retire = 1'b0;
    tx_ready    = 1'b0;
    rx_data     = '0;
    rx_valid    = 1'b0;
`ifdef BRANCH_STATS_EN
    br_x     = 1'b0;
    br_taken = 1'b0;
`endif

    // Reset with stores to TX and an RX load in flight
    st(32'h8000_0008, 32'h55);
    rx_valid = 1'b1;
    repeat (3) begin
      step();
      chk("rst_tx_valid", {31'b0, tx_valid}, 0);
      chk("rst_mw_hit", {31'b0, mw_hit}, 0);
    end
    ld(32'h8000_0004);
    #1;
    chk("rst_rx_ready", {31'b0, rx_ready}, 0);
    rx_valid = 1'b0;
    rst_n = 1'b1;
    ld(32'h8000_0010);
    step();
    chk("rst_cyc0", mw_rdata, 0);
    chk("rst_cyc0_hit", {31'b0, mw_hit}, 1);
    idle();
    step();

    // Vector table
    for (int i = 0; i < 10; i++) begin
      x_addr   = vt[i].addr;
      x_wdata  = vt[i].wdata;
      x_load   = vt[i].ld;
      x_store  = vt[i].st;
      x_valid  = vt[i].v;
      rx_valid = vt[i].rxv;
      rx_data  = vt[i].rxd;
      #1;
      chk($sformatf("v%0d_rxr", i), {31'b0, rx_ready}, {31'b0, vt[i].e_rxr});
      step();
      chk($sformatf("v%0d_hit", i), {31'b0, mw_hit}, {31'b0, vt[i].e_hit});
      chk($sformatf("v%0d_rd", i), mw_rdata, vt[i].e_rd);
    end
    idle();
    rx_valid = 1'b0;
    step();

    // TX buffer: hold, drop second byte, drain
    st(32'h8000_0008, 32'h41);
    step();
    idle();
    for (int i = 0; i < 5; i++) begin
      if (i == 2) st(32'h8000_0008, 32'h42);
      step();
      idle();
      chk("tx_valid_hold", {31'b0, tx_valid}, 1);
      chk("tx_data_hold", {24'b0, tx_data}, 32'h41);
    end
    ld(32'h8000_0000);
    step();
    chk("tx_status_full", mw_rdata, 0);
    st(32'h8000_0008, 32'h43);
    tx_ready = 1'b1;
    step();
    tx_ready = 1'b0;
    chk("tx_drained", {31'b0, tx_valid}, 0);
    chk("tx_drop_hs", {24'b0, tx_data}, 32'h41);
    ld(32'h8000_0000);
    step();
    chk("tx_status_empty", mw_rdata, 1);

    // Reset mid-handshake discards pending byte
    st(32'h8000_0008, 32'h99);
    step();
    chk("tx_full_pre", {31'b0, tx_valid}, 1);
    idle();
    tx_ready = 1'b1;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    tx_ready = 1'b0;
    chk("tx_rst_valid", {31'b0, tx_valid}, 0);
    chk("tx_rst_data", {24'b0, tx_data}, 0);

    // Counters: clear, 10 cycles with 7 retires
    st(32'h8000_0018, 0);
    step();
    idle();
    for (int i = 0; i < 10; i++) begin
      inst_retire = (i % 3 != 1);
      step();
    end
    inst_retire = 1'b0;
    ld(32'h8000_0014);
    step();
    chk("inst_7", mw_rdata, 7);
    ld(32'h8000_0010);
    step();
    chk("cyc_11", mw_rdata, 11);
    st(32'h8000_0018, 0);
    inst_retire = 1'b1;
    step();
    ld(32'h8000_0010);
    step();
    chk("cyc_clr", mw_rdata, 0);
    inst_retire = 1'b0;
    ld(32'h8000_0014);
    step();
    chk("inst_clr", mw_rdata, 1);

    // Wrap
    idle();
    force dut.u_cyc.r_q = 32'hFFFF_FFFF;
    #1;
    release dut.u_cyc.r_q;
    ld(32'h8000_0010);
    step();
    chk("cyc_max", mw_rdata, 32'hFFFF_FFFF);
    step();
    chk("cyc_wrap", mw_rdata, 0);

    // Flushed stores change nothing
    st(32'h8000_0008, 32'h66);
    x_valid = 1'b0;
    step();
    chk("flush_tx", {31'b0, tx_valid}, 0);
    st(32'h8000_0018, 0);
    x_valid = 1'b0;
    step();
    ld(32'h8000_0010);
    step();
    chk("flush_clr", mw_rdata, 3);

    // Branch statistics
    st(32'h8000_0018, 0);
    step();
    idle();
    x_valid = 1'b1;
`ifdef BRANCH_STATS_EN
    for (int i = 0; i < 6; i++) begin
      br_x     = (i != 2) && (i != 4);
      br_taken = (i != 3);
      x_valid  = 1'b1;
      step();
    end
    br_x = 1'b0;
    br_taken = 1'b0;
    ld(32'h8000_001C);
    step();
    chk("br_cnt", mw_rdata, 4);
    ld(32'h8000_0020);
    step();
    chk("brt_cnt", mw_rdata, 3);
`else
    step();
    ld(32'h8000_001C);
    step();
    chk("br_absent", mw_rdata, 0);
    ld(32'h8000_0020);
    step();
    chk("brt_absent", mw_rdata, 0);
`endif
    idle();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
